// File: rtl/traffic_pkg.sv
// Shared state encodings and lamp constants for the traffic-light sequencer.
package traffic_pkg;

   typedef enum logic [1:0] {
      S_RED   = 2'd0,
      S_GRN   = 2'd1,
      S_YEL   = 2'd2,
      S_FLASH = 2'd3
   } state_t;

   localparam logic [2:0] LAMP_R   = 3'b100;
   localparam logic [2:0] LAMP_Y   = 3'b010;
   localparam logic [2:0] LAMP_G   = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   // Lamp pattern shown on entry to a state ({r, y, g}).
   function automatic logic [2:0] lamp_of(input state_t s);
      logic [2:0] l;
      case (s)
         S_RED:   l = LAMP_R;
         S_GRN:   l = LAMP_G;
         S_YEL:   l = LAMP_Y;
         S_FLASH: l = LAMP_Y;
         default: l = LAMP_OFF;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Loadable down-counter that times each lamp phase and the flash half-period.
module tl_phase_timer #(
   parameter int               CNT_W   = 8,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_r;

   // Load has priority over decrement; otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= RST_VAL;
      end else if (load) begin
         cnt_r <= load_val;
      end else if (dec) begin
         cnt_r <= cnt_r - CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt  = cnt_r;
   assign zero = (cnt_r == CNT_W'(0));

endmodule

// File: rtl/traffic_light_ctrl.sv
// Cyclic red/green/yellow sequencer with pedestrian shortening, freeze and
// a yellow-flash safe mode driven by the downstream lamp checker.
module traffic_light_ctrl
   import traffic_pkg::*;
#(
   parameter int RED_CYC    = 20,
   parameter int GRN_CYC    = 15,
   parameter int YEL_CYC    = 5,
   parameter int FLASH_HALF = 4,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             ped_req,
   input  logic             fault_in,
   output logic             lamp_r,
   output logic             lamp_y,
   output logic             lamp_g,
   output logic [CNT_W-1:0] remain,
   output logic             phase_done
);

   localparam logic [CNT_W-1:0] RED_LD = CNT_W'(RED_CYC - 1);
   localparam logic [CNT_W-1:0] GRN_LD = CNT_W'(GRN_CYC - 1);
   localparam logic [CNT_W-1:0] YEL_LD = CNT_W'(YEL_CYC - 1);
   localparam logic [CNT_W-1:0] FL_LD  = CNT_W'(FLASH_HALF - 1);
   localparam logic [CNT_W-1:0] PED_LD = CNT_W'(2);

   state_t           state_r;
   state_t           next_state_s;
   logic [2:0]       lamps_r;
   logic             ped_r;
   logic             phase_done_r;
   logic             ped_eff_s;
   logic             t_load_s;
   logic             t_dec_s;
   logic [CNT_W-1:0] t_val_s;
   logic [CNT_W-1:0] cnt_s;
   logic             zero_s;

   tl_phase_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (RED_LD)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (t_load_s),
      .load_val (t_val_s),
      .dec      (t_dec_s),
      .cnt      (cnt_s),
      .zero     (zero_s)
   );

   // A request in the current cycle counts as already latched.
   assign ped_eff_s = ped_r | ped_req;

   // Successor in the normal R->G->Y->R rotation.
   always_comb begin
      case (state_r)
         S_RED:   next_state_s = S_GRN;
         S_GRN:   next_state_s = S_YEL;
         S_YEL:   next_state_s = S_RED;
         default: next_state_s = S_RED;
      endcase
   end

   // Timer control; in FLASH the same counter paces the yellow toggle.
   always_comb begin
      t_load_s = 1'b0;
      t_dec_s  = 1'b0;
      t_val_s  = RED_LD;
      if (fault_in) begin
         if ((state_r != S_FLASH) || zero_s) begin
            t_load_s = 1'b1;
            t_val_s  = FL_LD;
         end else begin
            t_dec_s = 1'b1;
         end
      end else if (state_r == S_FLASH) begin
         t_load_s = 1'b1;
         t_val_s  = RED_LD;
      end else if (!en) begin
         t_load_s = 1'b0;
      end else if (zero_s) begin
         t_load_s = 1'b1;
         case (next_state_s)
            S_GRN:   t_val_s = GRN_LD;
            S_YEL:   t_val_s = YEL_LD;
            default: t_val_s = RED_LD;
         endcase
      end else if ((state_r == S_GRN) && ped_eff_s && (cnt_s > PED_LD)) begin
         t_load_s = 1'b1;
         t_val_s  = PED_LD;
      end else begin
         t_dec_s = 1'b1;
      end
   end

   // Sequencer state, lamps, pedestrian latch and phase_done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= S_RED;
         lamps_r      <= LAMP_R;
         ped_r        <= 1'b0;
         phase_done_r <= 1'b0;
      end else if (fault_in) begin
         state_r      <= S_FLASH;
         ped_r        <= ped_eff_s;
         phase_done_r <= 1'b0;
         if (state_r != S_FLASH) begin
            lamps_r <= LAMP_Y;
         end else if (zero_s) begin
            lamps_r <= {1'b0, ~lamps_r[1], 1'b0};
         end else begin
            lamps_r <= lamps_r;
         end
      end else if (state_r == S_FLASH) begin
         state_r      <= S_RED;
         lamps_r      <= LAMP_R;
         ped_r        <= ped_req;
         phase_done_r <= 1'b0;
      end else if (!en) begin
         state_r      <= state_r;
         lamps_r      <= lamps_r;
         ped_r        <= ped_eff_s;
         phase_done_r <= 1'b0;
      end else if (zero_s) begin
         state_r      <= next_state_s;
         lamps_r      <= lamp_of(next_state_s);
         ped_r        <= (next_state_s == S_RED) ? ped_req : ped_eff_s;
         phase_done_r <= 1'b1;
      end else begin
         state_r      <= state_r;
         lamps_r      <= lamps_r;
         ped_r        <= ped_eff_s;
         phase_done_r <= 1'b0;
      end
   end

   assign lamp_r     = lamps_r[2];
   assign lamp_y     = lamps_r[1];
   assign lamp_g     = lamps_r[0];
   assign remain     = cnt_s;
   assign phase_done = phase_done_r;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with a phase-level reference model.
module tb_traffic_light_ctrl;

   localparam int RED = 20;
   localparam int GRN = 15;
   localparam int YEL = 5;
   localparam int FH  = 4;
   localparam int W   = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b0;
   logic         ped_req = 1'b0;
   logic         fault_in = 1'b0;
   logic         lamp_r, lamp_y, lamp_g, phase_done;
   logic [W-1:0] remain;

   traffic_light_ctrl #(
      .RED_CYC(RED), .GRN_CYC(GRN), .YEL_CYC(YEL), .FLASH_HALF(FH), .CNT_W(W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .ped_req(ped_req), .fault_in(fault_in),
      .lamp_r(lamp_r), .lamp_y(lamp_y), .lamp_g(lamp_g),
      .remain(remain), .phase_done(phase_done)
   );

   always #5 clk = ~clk;

   int n_run  = 0;
   int n_fail = 0;

   // Model: phase 0=red 1=green 2=yellow 3=flash; m_left = cycles still to show.
   int   plen [0:2] = '{RED, GRN, YEL};
   int   m_phase = 0;
   int   m_left  = RED;
   int   m_age   = 0;
   logic m_ped   = 1'b0;
   logic m_pd    = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_run++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int exp_lamps();
      if (m_phase == 3) return ((m_age / FH) % 2 == 0) ? 3'b010 : 3'b000;
      if (m_phase == 0) return 3'b100;
      if (m_phase == 1) return 3'b001;
      return 3'b010;
   endfunction

   initial begin
      logic eff;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_phase = 0; m_left = RED; m_age = 0; m_ped = 1'b0; m_pd = 1'b0;
         end else begin
            m_pd = 1'b0;
            eff  = m_ped | ped_req;
            if (fault_in) begin
               if (m_phase != 3) begin m_phase = 3; m_age = 0; end
               else m_age++;
               m_ped = eff;
            end else if (m_phase == 3) begin
               m_phase = 0; m_left = RED; m_ped = ped_req;
            end else if (!en) begin
               m_ped = eff;
            end else if (m_left == 1) begin
               m_phase = (m_phase + 1) % 3;
               m_left  = plen[m_phase];
               m_pd    = 1'b1;
               m_ped   = (m_phase == 0) ? ped_req : eff;
            end else if (m_phase == 1 && eff && m_left > 3) begin
               m_left = 3; m_ped = eff;
            end else begin
               m_left--; m_ped = eff;
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         chk("lamps", int'({lamp_r, lamp_y, lamp_g}), exp_lamps());
         chk("phase_done", int'(phase_done), int'(m_pd));
         if (m_phase != 3) chk("remain", int'(remain), m_left - 1);
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic run_until(input logic [2:0] want, input int bound, output int n);
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while ({lamp_r, lamp_y, lamp_g} != want && n < bound);
   endtask

   initial begin
      int n;
      int pd_q[$];
      int pd_exp [0:5] = '{20, 35, 40, 60, 75, 80};

      step(3);
      chk("reset_lamps", int'({lamp_r, lamp_y, lamp_g}), 3'b100);
      chk("reset_remain", int'(remain), 19);
      chk("reset_pd", int'(phase_done), 0);
      rst_n = 1'b1;
      en    = 1'b1;

      // Two full free-running periods.
      for (int e = 1; e <= 80; e++) begin
         step(1);
         if (phase_done) pd_q.push_back(e);
         if (e == 20) chk("first_green_remain", int'(remain), 14);
      end
      chk("pd_count", pd_q.size(), 6);
      for (int i = 0; i < 6 && i < pd_q.size(); i++) chk("pd_edge", pd_q[i], pd_exp[i]);

      // Freeze mid-red at remain 12.
      step(7);
      chk("pre_freeze_remain", int'(remain), 12);
      en = 1'b0;
      step(7);
      chk("frozen_remain", int'(remain), 12);
      chk("frozen_lamp_r", int'(lamp_r), 1);
      en = 1'b1;
      run_until(3'b001, 40, n);
      chk("red_after_freeze", n, 13);

      // Pedestrian pulse at green remain 10.
      step(4);
      chk("green_remain10", int'(remain), 10);
      ped_req = 1'b1;
      step(1);
      ped_req = 1'b0;
      chk("ped_short_remain", int'(remain), 2);
      run_until(3'b010, 40, n);
      chk("green_tail", n, 3);
      run_until(3'b100, 40, n);
      chk("yellow_full", n, 5);
      run_until(3'b001, 40, n);
      chk("red_full", n, 20);
      run_until(3'b010, 40, n);
      chk("green_full_latch_clear", n, 15);

      // Fault during green, held 20 cycles.
      run_until(3'b100, 40, n);
      run_until(3'b001, 40, n);
      step(5);
      fault_in = 1'b1;
      step(1);
      chk("flash_entry", int'({lamp_r, lamp_y, lamp_g}), 3'b010);
      step(4);
      chk("flash_toggle", int'({lamp_r, lamp_y, lamp_g}), 3'b000);
      step(15);
      fault_in = 1'b0;
      step(1);
      chk("flash_exit_lamps", int'({lamp_r, lamp_y, lamp_g}), 3'b100);
      chk("flash_exit_remain", int'(remain), 19);
      chk("flash_exit_pd", int'(phase_done), 0);

      // Request in red, then fault at the last green cycle.
      step(5);
      ped_req = 1'b1;
      step(1);
      ped_req = 1'b0;
      run_until(3'b001, 40, n);
      chk("red_rest", n, 14);
      step(1);
      chk("ped_from_red", int'(remain), 2);
      step(2);
      chk("green_last", int'(remain), 0);
      fault_in = 1'b1;
      step(1);
      chk("fault_wins", int'({lamp_r, lamp_y, lamp_g}), 3'b010);
      chk("fault_no_pd", int'(phase_done), 0);
      step(2);
      fault_in = 1'b0;
      step(1);
      chk("exit2_remain", int'(remain), 19);
      run_until(3'b001, 40, n);
      chk("red_after_fault", n, 20);
      run_until(3'b010, 40, n);
      chk("green_full_after_fault", n, 15);

      // Asynchronous reset between edges mid-yellow.
      step(2);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_lamps", int'({lamp_r, lamp_y, lamp_g}), 3'b100);
      chk("async_remain", int'(remain), 19);
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_until(3'b001, 40, n);
      chk("red_after_reset", n, 20);

      step(2);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
